core_branch_predictor: RTL
==========================

# core_branch_predictor

Dynamic branch predictor for the fetch stage. It is the consumer side of the execute-stage branch resolution. Fetch presents a PC each cycle and receives a same-cycle taken/target prediction. Resolved branches from execute train a direct-mapped table of 2-bit saturating counters and a tagged branch target buffer (BTB). A sequential sweep state machine initialises the tables after reset and after a flush.

## Interface
- XLEN, 64, address width
- ENTRIES, 64, table depth; power of two, ≥ 2; IDX = $clog2(ENTRIES), TAG = XLEN-IDX-2

- i_clk  input  1  clock, rising edge
- i_rst  input  1  synchronous, active-high reset
- i_bp_flush  input  1  invalidate all entries (fence.i); restarts the sweep
- i_bp_pc  input  XLEN  fetch PC to look up
- o_bp_ready  output  1  tables initialised; predictions and updates are honoured
- o_bp_hit  output  1  BTB valid and tag match for i_bp_pc
- o_bp_pred_taken  output  1  predicted taken
- o_bp_pred_target  output  XLEN  predicted target; {stored[XLEN-1:2], 2'b00}
- i_bp_upd_valid  input  1  resolution update this cycle
- i_bp_upd_pc  input  XLEN  PC of the resolved branch
- i_bp_upd_taken  input  1  resolved outcome
- i_bp_upd_target  input  XLEN  resolved target
- o_bp_perf_updates  output  32  count of accepted updates (macro only)
- o_bp_perf_mispred  output  32  count of accepted mispredicted updates (macro only)

## Operation
- Index = pc[IDX+1:2]; tag = pc[XLEN-1:IDX+2]; pc[1:0] ignored.
- Each entry holds: valid (1), tag (TAG), target[XLEN-1:2], ctr (2). Counter and BTB fields share the same index.
- **FSM states:** INIT, RUN.
  - i_rst → INIT, sweep pointer = 0.
  - In INIT, each cycle writes entry[ptr] to valid=0 and ctr=2'b01 (weakly not-taken), then ptr++.
  - At ptr == ENTRIES-1 the FSM moves to RUN.
  - In RUN, i_bp_flush → INIT with ptr = 0.
  - A flush during INIT restarts the sweep from 0.
- **Lookup** (combinational from the registered arrays):
  - o_bp_hit = ready & valid & tag match.
  - o_bp_pred_taken = o_bp_hit & ctr[1].
  - o_bp_pred_target = the stored target when o_bp_hit, else 0.
  - All prediction outputs are 0 when o_bp_ready = 0.
- **Update** (accepted only when i_bp_upd_valid & o_bp_ready):
  - ctr saturates: taken → min(ctr+1, 3); not taken → max(ctr-1, 0).
  - The counter is updated regardless of tag match.
  - Taken and i_bp_upd_target[1:0] == 0: write valid=1, tag and target.
  - Taken with a misaligned target: counter update only; the BTB is untouched.
  - Not taken: BTB fields unchanged.
  - Updates while not ready are dropped.
- **Mispredict definition** (for perf): the prediction the table would have produced for i_bp_upd_pc differs from i_bp_upd_taken, or the outcome is taken and the stored target differs.

## Timing
- Reset values: o_bp_ready = 0; o_bp_hit, o_bp_pred_taken = 0; o_bp_pred_target = 0; perf counters = 0.
- The sweep holds at ptr 0 while i_rst is high.
- Counting the first cycle with i_rst low as cycle 0: entries are written in cycles 0..ENTRIES-1, and o_bp_ready = 1 from cycle ENTRIES.
- After a flush sampled at edge N, o_bp_ready = 0 from N+1 and returns to 1 ENTRIES cycles later.
- An update accepted at edge N is visible to lookups from cycle N+1.
- A same-cycle lookup to the same index returns the pre-update state.
- Simultaneous flush and update: the flush wins and the update is dropped.
- Reset asserted mid-sweep or mid-run: next cycle is INIT with ptr 0; ready drops the cycle after the edge.

## Configuration
- CORE_BP_PERF_EN defined: o_bp_perf_updates and o_bp_perf_mispred are live 32-bit counters.
  - Both saturate at 32'hFFFF_FFFF.
  - Both clear only on i_rst; flush does not clear them.
- CORE_BP_PERF_EN undefined: both ports are tied to 0 and no counter flops exist.

## Test plan
- Reset release with ENTRIES=64 → o_bp_ready low for cycles 0..63, high at cycle 64; every lookup misses with pred_taken = 0.
- Three taken updates at pc=0x1000, target=0x2000 → lookup at 0x1000 gives hit=1, pred_taken=1, target=0x2000. One not-taken update → still taken (ctr 3→2). Two more not-taken → pred_taken=0, hit=1.
- Taken update at 0x1000, then lookup at 0x1000 + (ENTRIES·4) (same index, different tag) → hit=0, pred_taken=0.
- Taken update with target=0x2001 → ctr changes but hit stays 0. With CORE_BP_PERF_EN, updates increments and mispred increments.
- Flush in RUN after training, with a simultaneous update → ready low for 64 cycles, then all lookups miss; the update is not applied.
- i_rst asserted at sweep ptr 30 → sweep restarts and ready rises 64 cycles after release; a lookup concurrent with an update to the same index returns the old counter value.

Source files
------------

// File: rtl/core_branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped 2-bit counters plus a tagged BTB, initialised by a sweep FSM.
// Optional performance counters are built when CORE_BP_PERF_EN is defined.
//
// state | meaning
// ------+----------------------------------------------------------
// INIT  | sweeping entries to invalid / weakly not-taken; not ready
// RUN   | lookups and training updates honoured
module core_branch_predictor #(
    parameter int XLEN    = 64,
    parameter int ENTRIES = 64
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_bp_flush,
    input  logic [XLEN-1:0] i_bp_pc,
    output logic            o_bp_ready,
    output logic            o_bp_hit,
    output logic            o_bp_pred_taken,
    output logic [XLEN-1:0] o_bp_pred_target,
    input  logic            i_bp_upd_valid,
    input  logic [XLEN-1:0] i_bp_upd_pc,
    input  logic            i_bp_upd_taken,
    input  logic [XLEN-1:0] i_bp_upd_target,
    output logic [31:0]     o_bp_perf_updates,
    output logic [31:0]     o_bp_perf_mispred
);
    localparam int IDX = $clog2(ENTRIES);
    localparam int TAG = XLEN - IDX - 2;
    localparam logic [IDX-1:0] LAST = IDX'(ENTRIES - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t         state_q, state_d;
    logic [IDX-1:0] ptr_q, ptr_d;
    logic           sweep_we;
    logic           upd_accept;

    logic            valid_q [ENTRIES];
    logic [TAG-1:0]  tag_q   [ENTRIES];
    logic [XLEN-3:0] tgt_q   [ENTRIES];
    logic [1:0]      ctr_q   [ENTRIES];

    logic [IDX-1:0] lk_idx, up_idx;
    logic [TAG-1:0] lk_tag;
    logic [1:0]     ctr_cur, ctr_nxt;

    assign lk_idx = i_bp_pc[IDX+1:2];
    assign lk_tag = i_bp_pc[XLEN-1:IDX+2];
    assign up_idx = i_bp_upd_pc[IDX+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{i_bp_pc[1:0], i_bp_upd_pc[1:0]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_INIT: begin
                if (i_bp_flush) begin
                    ptr_d = '0;
                end else if (ptr_q == LAST) begin
                    state_d = ST_RUN;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + IDX'(1);
                end
            end
            ST_RUN: begin
                if (i_bp_flush) begin
                    state_d = ST_INIT;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
                ptr_d   = '0;
            end
        endcase
    end

    // Flush and reset both take priority over any update presented in the same cycle.
    always_comb begin
        o_bp_ready = (state_q == ST_RUN);
        sweep_we   = (state_q == ST_INIT) && !i_bp_flush && !i_rst;
        upd_accept = i_bp_upd_valid && o_bp_ready && !i_bp_flush && !i_rst;
    end

    always_comb begin
        o_bp_hit         = o_bp_ready & valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
        o_bp_pred_taken  = o_bp_hit & ctr_q[lk_idx][1];
        o_bp_pred_target = o_bp_hit ? {tgt_q[lk_idx], 2'b00} : '0;
    end

    assign ctr_cur = ctr_q[up_idx];

    always_comb begin
        ctr_nxt = ctr_cur;
        if (i_bp_upd_taken) begin
            if (ctr_cur != 2'b11) ctr_nxt = ctr_cur + 2'd1;
        end else begin
            if (ctr_cur != 2'b00) ctr_nxt = ctr_cur - 2'd1;
        end
    end

    // Counter trains on every accepted update even without a tag match; the BTB only takes aligned taken targets.
    always_ff @(posedge i_clk) begin
        if (sweep_we) begin
            valid_q[ptr_q] <= 1'b0;
            ctr_q[ptr_q]   <= 2'b01;
        end else if (upd_accept) begin
            ctr_q[up_idx] <= ctr_nxt;
            if (i_bp_upd_taken && (i_bp_upd_target[1:0] == 2'b00)) begin
                valid_q[up_idx] <= 1'b1;
                tag_q[up_idx]   <= i_bp_upd_pc[XLEN-1:IDX+2];
                tgt_q[up_idx]   <= i_bp_upd_target[XLEN-1:2];
            end
        end
    end

`ifdef CORE_BP_PERF_EN
    logic [TAG-1:0]  up_tag;
    logic            up_hit, up_pred_taken, mispred;
    logic [XLEN-1:0] up_pred_tgt;
    logic [31:0]     perf_upd_q, perf_mp_q;

    assign up_tag        = i_bp_upd_pc[XLEN-1:IDX+2];
    assign up_hit        = valid_q[up_idx] & (tag_q[up_idx] == up_tag);
    assign up_pred_taken = up_hit & ctr_cur[1];
    assign up_pred_tgt   = up_hit ? {tgt_q[up_idx], 2'b00} : '0;
    assign mispred       = (up_pred_taken != i_bp_upd_taken) |
                           (i_bp_upd_taken & (up_pred_tgt != i_bp_upd_target));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            perf_upd_q <= '0;
            perf_mp_q  <= '0;
        end else if (upd_accept) begin
            if (perf_upd_q != 32'hFFFF_FFFF) perf_upd_q <= perf_upd_q + 32'd1;
            if (mispred && (perf_mp_q != 32'hFFFF_FFFF)) perf_mp_q <= perf_mp_q + 32'd1;
        end
    end

    assign o_bp_perf_updates = perf_upd_q;
    assign o_bp_perf_mispred = perf_mp_q;
`else
    logic unused_upd_tag;
    assign unused_upd_tag    = ^i_bp_upd_pc[XLEN-1:IDX+2];
    assign o_bp_perf_updates = '0;
    assign o_bp_perf_mispred = '0;
`endif

endmodule
